// File: rtl/ctrl_issue_stage_pkg.sv
// Shared definitions for the control-issue slice: control word layout,
// ALU / immediate encodings, RV32I opcodes and the issue FSM states.
// Optional feature macro: CTRL_ISSUE_RVM_EN (enables M-extension decode).
package common_pkg;

    localparam int CTRL_W = 16;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // Packed MSB first: illegal is bit 15, alu_op occupies bits 4:0.
    typedef struct packed {
        logic      illegal;
        logic      jump;
        logic      branch;
        logic      mem_to_reg;
        logic      reg_write;
        logic      mem_write;
        logic      mem_read;
        imm_type_e imm_type;
        logic      alu_src;
        alu_op_e   alu_op;
    } control_t;

    localparam control_t CTRL_NOP = '0;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_HALT   = 2'd2
    } issue_state_e;

    // Base-ISA ALU operation selected by funct3; alt picks SUB/SRA.
    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_issue_stage_if.sv
// Handshake bundles around the issue stage: instruction input from fetch
// and control-word output to the execute stage.
//
// Both channels use strict valid/ready: a transfer happens on a rising clock
// edge where valid && ready are both 1; once valid is raised, the sender holds
// valid and its payload stable until that transfer; ready may depend on valid.
interface ctrl_issue_instr_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

interface ctrl_issue_ctrl_if;
    import common_pkg::*;

    logic              ctrl_valid;
    logic              ctrl_ready;
    logic [CTRL_W-1:0] control_out;
    logic [4:0]        rd_out;

    modport master (output ctrl_valid, output control_out, output rd_out, input ctrl_ready);
    modport slave  (input ctrl_valid, input control_out, input rd_out, output ctrl_ready);
endinterface

// File: rtl/ctrl_issue_stage_ctrl_decoder.sv
// Combinational RV32I decoder: instruction word to control word, register
// indices and source-use flags. Illegal encodings yield a word with only the
// illegal bit set. With CTRL_ISSUE_RVM_EN defined, OP with funct7=0000001
// decodes to the M-extension ALU codes; otherwise it is illegal.
module ctrl_decoder
    import common_pkg::*;
(
    input  logic [31:0] instr,
    output control_t    ctrl,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        rs1_used,
    output logic        rs2_used
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_field;
    logic       illegal;

    assign opcode   = instr[6:0];
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign rd_field = instr[11:7];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];

    // Opcode/funct decode into control fields, then x0 and illegal cleanup.
    always_comb begin
        ctrl     = CTRL_NOP;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        illegal  = 1'b0;
        rd       = 5'd0;
        case (opcode)
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm_type  = IMM_U;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_PASSB;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm_type  = IMM_U;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OPC_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.imm_type  = IMM_J;
                ctrl.alu_op    = ALU_ADD;
            end
            OPC_JALR: begin
                illegal        = (f3 != 3'b000);
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.imm_type  = IMM_I;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                rs1_used       = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.imm_type = IMM_B;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                case (f3)
                    3'b000, 3'b001: ctrl.alu_op = ALU_SUB;
                    3'b100, 3'b101: ctrl.alu_op = ALU_SLT;
                    3'b110, 3'b111: ctrl.alu_op = ALU_SLTU;
                    default:        illegal     = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                illegal         = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                                    f3 == 3'b100 || f3 == 3'b101);
                ctrl.mem_read   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.imm_type   = IMM_I;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                rs1_used        = 1'b1;
            end
            OPC_STORE: begin
                illegal        = (f3 > 3'b010);
                ctrl.mem_write = 1'b1;
                ctrl.imm_type  = IMM_S;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
            end
            OPC_OPIMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm_type  = IMM_I;
                ctrl.alu_src   = 1'b1;
                rs1_used       = 1'b1;
                if (f3 == 3'b001) begin
                    illegal     = (f7 != 7'b0000000);
                    ctrl.alu_op = ALU_SLL;
                end else if (f3 == 3'b101) begin
                    illegal     = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    ctrl.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                end else begin
                    ctrl.alu_op = alu_op_from_f3(f3, 1'b0);
                end
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                if (f7 == 7'b0000000) begin
                    ctrl.alu_op = alu_op_from_f3(f3, 1'b0);
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    ctrl.alu_op = alu_op_from_f3(f3, 1'b1);
`ifdef CTRL_ISSUE_RVM_EN
                end else if (f7 == 7'b0000001) begin
                    // MUL..REMU map onto 16 + funct3.
                    ctrl.alu_op = alu_op_e'({2'b10, f3});
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_FENCE, OPC_SYSTEM: begin
                // No register or memory effect at this stage.
                ctrl = CTRL_NOP;
            end
            default: illegal = 1'b1;
        endcase

        // Writes to x0 are discarded; rd is only reported for real writes.
        if (rd_field == 5'd0) begin
            ctrl.reg_write = 1'b0;
        end
        if (ctrl.reg_write) begin
            rd = rd_field;
        end

        if (illegal) begin
            ctrl         = CTRL_NOP;
            ctrl.illegal = 1'b1;
            rd           = 5'd0;
            rs1_used     = 1'b0;
            rs2_used     = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_issue_stage.sv
// Issue stage: decodes fetched RV32I instructions and holds the control word
// in a handshaken output register. Inserts a one-cycle NOP bubble on a
// load-use hazard and halts issue after an illegal opcode until flush_i.
// Optional feature macro: CTRL_ISSUE_RVM_EN (handled in ctrl_decoder).
module ctrl_issue_stage
    import common_pkg::control_t, common_pkg::issue_state_e, common_pkg::CTRL_NOP,
           common_pkg::ST_RUN, common_pkg::ST_BUBBLE, common_pkg::ST_HALT;
#(
    parameter int CTRL_W          = 16,
    parameter bit RESET_PC_BUBBLE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    ctrl_issue_instr_if.slave   in_if,
    ctrl_issue_ctrl_if.master   out_if,
    output logic                illegal_instr,
    output issue_state_e        dbg_state
);

    // The control word layout is fixed by the package.
    if (CTRL_W != common_pkg::CTRL_W) begin : g_ctrl_w_check
        $error("ctrl_issue_stage: CTRL_W must equal common_pkg::CTRL_W");
    end

    control_t     dec_ctrl;
    logic [4:0]   dec_rs1, dec_rs2, dec_rd;
    logic         dec_rs1_used, dec_rs2_used;

    issue_state_e state_q, state_d;
    logic         ctrl_valid_q, ctrl_valid_d;
    control_t     control_q, control_d;
    logic [4:0]   rd_q, rd_d;
    logic         illegal_q, illegal_d;

    logic         hazard;
    logic         out_free;
    logic         instr_ready;
    logic         accept;

    ctrl_decoder u_dec (
        .instr    (in_if.instr),
        .ctrl     (dec_ctrl),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used)
    );

    // Load-use hazard against the word currently held in the output register.
    always_comb begin
        hazard = ctrl_valid_q && control_q.mem_read && (rd_q != 5'd0) &&
                 ((dec_rs1_used && (dec_rs1 == rd_q)) ||
                  (dec_rs2_used && (dec_rs2 == rd_q)));
    end

    assign out_free    = !ctrl_valid_q || out_if.ctrl_ready;
    assign instr_ready = (state_q == ST_RUN) && !hazard && out_free && !flush_i;
    assign accept      = in_if.instr_valid && instr_ready;

    // Next-state for FSM, output register and sticky illegal flag.
    always_comb begin
        state_d      = state_q;
        ctrl_valid_d = ctrl_valid_q;
        control_d    = control_q;
        rd_d         = rd_q;
        illegal_d    = illegal_q;
        if (flush_i) begin
            state_d      = ST_RUN;
            ctrl_valid_d = 1'b0;
            control_d    = CTRL_NOP;
            rd_d         = 5'd0;
            illegal_d    = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        ctrl_valid_d = 1'b1;
                        control_d    = dec_ctrl;
                        rd_d         = dec_rd;
                        if (dec_ctrl.illegal) begin
                            illegal_d = 1'b1;
                            state_d   = ST_HALT;
                        end
                    end else if (in_if.instr_valid && hazard && out_free) begin
                        ctrl_valid_d = 1'b1;
                        control_d    = CTRL_NOP;
                        rd_d         = 5'd0;
                        state_d      = ST_BUBBLE;
                    end else if (out_if.ctrl_ready) begin
                        ctrl_valid_d = 1'b0;
                    end
                end
                ST_BUBBLE: begin
                    state_d = ST_RUN;
                    if (out_if.ctrl_ready) begin
                        ctrl_valid_d = 1'b0;
                    end
                end
                default: begin
                    if (out_if.ctrl_ready) begin
                        ctrl_valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    // State and output registers; reset discards any in-flight word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            ctrl_valid_q <= RESET_PC_BUBBLE;
            control_q    <= CTRL_NOP;
            rd_q         <= 5'd0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_valid_q <= ctrl_valid_d;
            control_q    <= control_d;
            rd_q         <= rd_d;
            illegal_q    <= illegal_d;
        end
    end

    assign in_if.instr_ready  = instr_ready;
    assign out_if.ctrl_valid  = ctrl_valid_q;
    assign out_if.control_out = control_q;
    assign out_if.rd_out      = rd_q;
    assign illegal_instr      = illegal_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_ctrl_issue_stage.sv
// Directed bench for ctrl_issue_stage with hand-computed control words.
module tb_ctrl_issue_stage;

    logic       clk;
    logic       rst;
    logic       flush_i;
    logic       illegal_instr;
    logic [1:0] dbg_state;
    int         n_vec;
    int         n_err;

    ctrl_issue_instr_if in_if ();
    ctrl_issue_ctrl_if  out_if ();

    ctrl_issue_stage #(.CTRL_W(16), .RESET_PC_BUBBLE(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_if         (in_if),
        .out_if        (out_if),
        .illegal_instr (illegal_instr),
        .dbg_state     (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        flush_i = 1'b0;
        in_if.instr_valid = 1'b0;
        in_if.instr = 32'h0;
        out_if.ctrl_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic present(input logic [31:0] w);
        in_if.instr = w;
        in_if.instr_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush_i = 1'b0;
        in_if.instr_valid = 1'b0;
        in_if.instr = 32'h0;
        out_if.ctrl_ready = 1'b0;
        tick();
        n_vec++; if (out_if.ctrl_valid !== 1'b1) begin n_err++; $display("FAIL rst_valid: got %b want 1", out_if.ctrl_valid); end
        n_vec++; if (out_if.control_out !== 16'h0000) begin n_err++; $display("FAIL rst_ctrl: got %h want 0000", out_if.control_out); end
        n_vec++; if (out_if.rd_out !== 5'd0) begin n_err++; $display("FAIL rst_rd: got %0d want 0", out_if.rd_out); end
        n_vec++; if (illegal_instr !== 1'b0) begin n_err++; $display("FAIL rst_illegal: got %b want 0", illegal_instr); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        n_vec++; if (in_if.instr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", in_if.instr_ready); end
        rst = 1'b0;
        tick();
        n_vec++; if (out_if.ctrl_valid !== 1'b1) begin n_err++; $display("FAIL bubble_hold: got %b want 1", out_if.ctrl_valid); end
        out_if.ctrl_ready = 1'b1;
        tick();
        n_vec++; if (out_if.ctrl_valid !== 1'b0) begin n_err++; $display("FAIL bubble_drain: got %b want 0", out_if.ctrl_valid); end
    endtask

    task automatic test_decode_latency();
        apply_reset();
        out_if.ctrl_ready = 1'b1;
        present(32'h002081B3);
        #1;
        n_vec++; if (in_if.instr_ready !== 1'b1) begin n_err++; $display("FAIL dec_ready: got %b want 1", in_if.instr_ready); end
        tick();
        in_if.instr_valid = 1'b0;
        n_vec++; if (out_if.ctrl_valid !== 1'b1) begin n_err++; $display("FAIL dec_valid: got %b want 1", out_if.ctrl_valid); end
        n_vec++; if (out_if.control_out !== 16'h0800) begin n_err++; $display("FAIL dec_add: got %h want 0800", out_if.control_out); end
        n_vec++; if (out_if.rd_out !== 5'd3) begin n_err++; $display("FAIL dec_rd: got %0d want 3", out_if.rd_out); end
        tick();
        n_vec++; if (out_if.ctrl_valid !== 1'b0) begin n_err++; $display("FAIL dec_drain: got %b want 0", out_if.ctrl_valid); end
    endtask

    task automatic test_load_use();
        present(32'h0000A283);
        tick();
        n_vec++; if (out_if.control_out !== 16'h1A60) begin n_err++; $display("FAIL lw_ctrl: got %h want 1A60", out_if.control_out); end
        n_vec++; if (out_if.rd_out !== 5'd5) begin n_err++; $display("FAIL lw_rd: got %0d want 5", out_if.rd_out); end
        present(32'h00128333);
        #1;
        n_vec++; if (in_if.instr_ready !== 1'b0) begin n_err++; $display("FAIL hz_ready: got %b want 0", in_if.instr_ready); end
        tick();
        n_vec++; if (out_if.ctrl_valid !== 1'b1) begin n_err++; $display("FAIL nop_valid: got %b want 1", out_if.ctrl_valid); end
        n_vec++; if (out_if.control_out !== 16'h0000) begin n_err++; $display("FAIL nop_ctrl: got %h want 0000", out_if.control_out); end
        n_vec++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL nop_state: got %0d want 1", dbg_state); end
        #1;
        n_vec++; if (in_if.instr_ready !== 1'b0) begin n_err++; $display("FAIL bubble_ready: got %b want 0", in_if.instr_ready); end
        tick();
        n_vec++; if (in_if.instr_ready !== 1'b1) begin n_err++; $display("FAIL post_bubble_ready: got %b want 1", in_if.instr_ready); end
        tick();
        in_if.instr_valid = 1'b0;
        n_vec++; if (out_if.control_out !== 16'h0800) begin n_err++; $display("FAIL lu_add_ctrl: got %h want 0800", out_if.control_out); end
        n_vec++; if (out_if.rd_out !== 5'd6) begin n_err++; $display("FAIL lu_add_rd: got %0d want 6", out_if.rd_out); end
    endtask

    task automatic test_backpressure();
        out_if.ctrl_ready = 1'b0;
        present(32'h002081B3);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (out_if.ctrl_valid !== 1'b1 || out_if.control_out !== 16'h0800 || out_if.rd_out !== 5'd6)
                begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b c=%h rd=%0d want v=1 c=0800 rd=6", i, out_if.ctrl_valid, out_if.control_out, out_if.rd_out); end
            n_vec++; if (in_if.instr_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_if.instr_ready); end
            tick();
        end
        out_if.ctrl_ready = 1'b1;
        #1;
        n_vec++; if (in_if.instr_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_if.instr_ready); end
        tick();
        in_if.instr_valid = 1'b0;
        n_vec++; if (out_if.ctrl_valid !== 1'b1 || out_if.rd_out !== 5'd3)
            begin n_err++; $display("FAIL bp_next: got v=%b rd=%0d want v=1 rd=3", out_if.ctrl_valid, out_if.rd_out); end
        tick();
        n_vec++; if (out_if.ctrl_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", out_if.ctrl_valid); end
    endtask

    task automatic test_x0_and_use();
        present(32'h00208033);
        tick();
        n_vec++; if (out_if.control_out !== 16'h0000 || out_if.rd_out !== 5'd0)
            begin n_err++; $display("FAIL x0_add: got c=%h rd=%0d want c=0000 rd=0", out_if.control_out, out_if.rd_out); end
        present(32'h0000A003);
        tick();
        n_vec++; if (out_if.control_out !== 16'h1260) begin n_err++; $display("FAIL x0_lw: got %h want 1260", out_if.control_out); end
        present(32'h00100333);
        #1;
        n_vec++; if (in_if.instr_ready !== 1'b1) begin n_err++; $display("FAIL x0_nohz: got %b want 1", in_if.instr_ready); end
        tick();
        n_vec++; if (out_if.rd_out !== 5'd6) begin n_err++; $display("FAIL x0_next_rd: got %0d want 6", out_if.rd_out); end
        present(32'h0000A283);
        tick();
        present(32'h00028337);
        #1;
        n_vec++; if (in_if.instr_ready !== 1'b1) begin n_err++; $display("FAIL lui_nohz: got %b want 1", in_if.instr_ready); end
        tick();
        n_vec++; if (out_if.control_out !== 16'h092A) begin n_err++; $display("FAIL lui_ctrl: got %h want 092A", out_if.control_out); end
        present(32'h0000A283);
        tick();
        present(32'h005083B3);
        #1;
        n_vec++; if (in_if.instr_ready !== 1'b0) begin n_err++; $display("FAIL rs2_hz: got %b want 0", in_if.instr_ready); end
        in_if.instr_valid = 1'b0;
        tick();
        n_vec++; if (out_if.ctrl_valid !== 1'b0 || dbg_state !== 2'd0)
            begin n_err++; $display("FAIL rs2_drop: got v=%b st=%0d want v=0 st=0", out_if.ctrl_valid, dbg_state); end
    endtask

    task automatic test_illegal_flush();
        present(32'hFFFFFFFF);
        #1;
        n_vec++; if (in_if.instr_ready !== 1'b1) begin n_err++; $display("FAIL ill_accept: got %b want 1", in_if.instr_ready); end
        tick();
        present(32'h002081B3);
        n_vec++; if (illegal_instr !== 1'b1) begin n_err++; $display("FAIL ill_flag: got %b want 1", illegal_instr); end
        n_vec++; if (out_if.control_out[15] !== 1'b1 || out_if.ctrl_valid !== 1'b1)
            begin n_err++; $display("FAIL ill_word: got c15=%b v=%b want 1 1", out_if.control_out[15], out_if.ctrl_valid); end
        n_vec++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL ill_state: got %0d want 2", dbg_state); end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (in_if.instr_ready !== 1'b0) begin n_err++; $display("FAIL halt_ready[%0d]: got %b want 0", i, in_if.instr_ready); end
            tick();
        end
        n_vec++; if (illegal_instr !== 1'b1 || out_if.control_out[15] !== 1'b1)
            begin n_err++; $display("FAIL halt_sticky: got f=%b c15=%b want 1 1", illegal_instr, out_if.control_out[15]); end
        flush_i = 1'b1;
        #1;
        n_vec++; if (in_if.instr_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", in_if.instr_ready); end
        tick();
        flush_i = 1'b0;
        n_vec++; if (out_if.ctrl_valid !== 1'b0 || illegal_instr !== 1'b0 || dbg_state !== 2'd0)
            begin n_err++; $display("FAIL flush_out: got v=%b f=%b st=%0d want 0 0 0", out_if.ctrl_valid, illegal_instr, dbg_state); end
        #1;
        n_vec++; if (in_if.instr_ready !== 1'b1) begin n_err++; $display("FAIL flush_resume: got %b want 1", in_if.instr_ready); end
        in_if.instr_valid = 1'b0;
        tick();
    endtask

    task automatic test_rvm();
        present(32'h022081B3);
        tick();
        in_if.instr_valid = 1'b0;
`ifdef CTRL_ISSUE_RVM_EN
        n_vec++; if (out_if.control_out !== 16'h0810 || out_if.rd_out !== 5'd3 || illegal_instr !== 1'b0)
            begin n_err++; $display("FAIL mul_dec: got c=%h rd=%0d f=%b want c=0810 rd=3 f=0", out_if.control_out, out_if.rd_out, illegal_instr); end
`else
        n_vec++; if (out_if.control_out !== 16'h8000 || illegal_instr !== 1'b1)
            begin n_err++; $display("FAIL mul_illegal: got c=%h f=%b want c=8000 f=1", out_if.control_out, illegal_instr); end
`endif
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        out_if.ctrl_ready = 1'b0;
        present(32'h002081B3);
        tick();
        in_if.instr_valid = 1'b0;
        n_vec++; if (out_if.control_out !== 16'h0800 || out_if.ctrl_valid !== 1'b1)
            begin n_err++; $display("FAIL ar_pre: got c=%h v=%b want c=0800 v=1", out_if.control_out, out_if.ctrl_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (out_if.ctrl_valid !== 1'b1) begin n_err++; $display("FAIL ar_valid: got %b want 1", out_if.ctrl_valid); end
        n_vec++; if (out_if.control_out !== 16'h0000 || out_if.rd_out !== 5'd0)
            begin n_err++; $display("FAIL ar_word: got c=%h rd=%0d want c=0000 rd=0", out_if.control_out, out_if.rd_out); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_decode_latency();
        test_load_use();
        test_backpressure();
        test_x0_and_use();
        test_illegal_flush();
        test_rvm();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
